controlador_sram_64b: RTL

//  Memory-side stage driven by FSM_prueba_escritura_mem.
//  - Takes its leer/escribir requests, 64-bit write data and 18-bit address.
//  - Performs each request as four 16-bit accesses on an external async SRAM
//    (256K x 16, ce/oe/we/ub/lb active-low).
//  - Returns operacion_completada and datos_leidos to the test FSM.

---
 rtl/controlador_sram_64b_if.sv | 20 ++
 rtl/controlador_sram_64b.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/controlador_sram_64b_if.sv
// Request/response bus between the memory test FSM and the 64-bit SRAM controller.
interface controlador_sram_64b_if;
    logic        leer;
    logic        escribir;
    logic [17:0] direccion_memoria;
    logic [63:0] datos_por_escribir;
    logic        operacion_completada;
    logic [63:0] datos_leidos;
    logic        ocupado;

    modport master (
        output leer, escribir, direccion_memoria, datos_por_escribir,
        input  operacion_completada, datos_leidos, ocupado
    );

    modport slave (
        input  leer, escribir, direccion_memoria, datos_por_escribir,
        output operacion_completada, datos_leidos, ocupado
    );
endinterface

// File: rtl/controlador_sram_64b.sv
// 64-bit read/write requests carried out as four 16-bit accesses on an
// asynchronous 256K x 16 SRAM. Halfword k lives at (base + k) mod 2^18.
module controlador_sram_64b #(
    parameter int CICLOS_ACCESO = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    controlador_sram_64b_if.slave        bus,
    output logic [17:0]                  sram_addr,
    inout  wire  [15:0]                  sram_dq,
    output logic                         sram_ce_n,
    output logic                         sram_oe_n,
    output logic                         sram_we_n,
    output logic                         sram_ub_n,
    output logic                         sram_lb_n
);

    localparam int CW = (CICLOS_ACCESO > 1) ? $clog2(CICLOS_ACCESO) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD,
        S_FIN
    } estado_t;

    estado_t        r_estado;
    estado_t        w_estado_sig;
    logic [1:0]     r_k;
    logic [CW-1:0]  r_cnt;
    logic [17:0]    r_base;
    logic [63:0]    r_wdata;
    logic [63:0]    r_rbuf;
    logic [63:0]    r_datos_leidos;

    logic           w_ultimo_ciclo;
    logic           w_ultimo_hw;
    logic           w_dq_oe;
    logic [15:0]    w_dq_out;

    assign w_ultimo_ciclo = (r_cnt == CW'(CICLOS_ACCESO - 1));
    assign w_ultimo_hw    = (r_k == 2'd3);
    assign w_dq_out       = r_wdata[{r_k, 4'b0000} +: 16];
    assign sram_dq        = w_dq_oe ? w_dq_out : 16'bz;

    assign bus.operacion_completada = (r_estado == S_FIN);
    assign bus.ocupado              = (r_estado != S_IDLE) && (r_estado != S_FIN);
    assign bus.datos_leidos         = r_datos_leidos;

    // State register; a low reset at any edge aborts the current request.
    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (!reset) r_estado <= S_IDLE;
        else        r_estado <= w_estado_sig;
    end

    // Next-state logic and SRAM strobe decode from the current state.
    always_comb begin
        // NOTE: every output gets a default first; a path that leaves one
        // unassigned would infer a latch.
        w_estado_sig = r_estado;
        sram_ce_n    = 1'b1;
        sram_oe_n    = 1'b1;
        sram_we_n    = 1'b1;
        sram_ub_n    = 1'b1;
        sram_lb_n    = 1'b1;
        sram_addr    = '0;
        w_dq_oe      = 1'b0;
        unique case (r_estado)
            S_IDLE: begin
                if (bus.escribir)  w_estado_sig = S_WR_SETUP;
                else if (bus.leer) w_estado_sig = S_RD;
            end
            S_RD: begin
                {sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n} = 4'b0000;
                sram_addr = r_base + 18'(r_k);
                if (w_ultimo_ciclo && w_ultimo_hw) w_estado_sig = S_FIN;
            end
            S_WR_SETUP: begin
                {sram_ce_n, sram_ub_n, sram_lb_n} = 3'b000;
                sram_addr    = r_base + 18'(r_k);
                w_dq_oe      = 1'b1;
                w_estado_sig = S_WR_PULSE;
            end
            S_WR_PULSE: begin
                {sram_ce_n, sram_we_n, sram_ub_n, sram_lb_n} = 4'b0000;
                sram_addr = r_base + 18'(r_k);
                w_dq_oe   = 1'b1;
                if (w_ultimo_ciclo) w_estado_sig = S_WR_HOLD;
            end
            S_WR_HOLD: begin
                {sram_ce_n, sram_ub_n, sram_lb_n} = 3'b000;
                sram_addr    = r_base + 18'(r_k);
                w_dq_oe      = 1'b1;
                w_estado_sig = w_ultimo_hw ? S_FIN : S_WR_SETUP;
            end
            S_FIN: w_estado_sig = S_IDLE;
            default: w_estado_sig = S_IDLE;
        endcase
    end

    // Halfword index, access-cycle counter and the visible read word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_k            <= '0;
            r_cnt          <= '0;
            r_datos_leidos <= '0;
        end else begin
            unique case (r_estado)
                S_IDLE: begin
                    r_k   <= '0;
                    r_cnt <= '0;
                end
                S_RD, S_WR_PULSE: begin
                    if (w_ultimo_ciclo) begin
                        r_cnt <= '0;
                        if (r_estado == S_RD) begin
                            r_k <= r_k + 2'd1;
                            // Whole word published at once, entering FIN.
                            if (w_ultimo_hw) r_datos_leidos <= {sram_dq, r_rbuf[47:0]};
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_WR_HOLD: r_k <= r_k + 2'd1;
                default: ;
            endcase
        end
    end

    // Request latches and read assembly buffer.
    always_ff @(posedge clk) begin
        // NOTE: these data registers are left out of reset; each is loaded
        // before any state that reads it, so resetting them buys nothing.
        if (r_estado == S_IDLE && (bus.escribir || bus.leer)) begin
            r_base <= bus.direccion_memoria;
            if (bus.escribir) r_wdata <= bus.datos_por_escribir;
        end
        if (r_estado == S_RD && w_ultimo_ciclo) r_rbuf[{r_k, 4'b0000} +: 16] <= sram_dq;
    end

endmodule
